smem_result_writer: RTL and testbench
=====================================

# smem_result_writer

Downstream drain stage for the SMEM result RAM block. Once the RAM block raises `output_request`, this block grants `output_permit` and captures the 512-bit result lines it streams. It buffers those lines in a small FIFO and back-pressures the RAM block through `stall`. It then issues the lines as sequential host line-writes, and finishes the batch with one status line and a `done` pulse.

## Interface
- `FIFO_DEPTH`, default 16: line buffer depth; must be a power of 2 and at least 8.
- `STALL_THRESH`, default FIFO_DEPTH-4: occupancy at or above which `stall` is asserted.
- `ADDR_W`, default 32: width of host line addresses.

Ports (one clock; reset is synchronous and active-high):
- `clk`  in  1  sole clock; everything samples on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `start`  in  1  one-cycle pulse that arms the block for a batch.
- `base_addr`  in  ADDR_W  first host line address for data lines; latched on `start`.
- `status_addr`  in  ADDR_W  host line address for the status line; latched on `start`.
- `output_request`  in  1  from the RAM block: results are ready.
- `output_permit`  out  1  to the RAM block: streaming is allowed.
- `output_data`  in  512  result line from the RAM block.
- `output_valid`  in  1  `output_data` is valid this cycle.
- `output_finish`  in  1  RAM block has sent all lines (sticky high).
- `stall`  out  1  to the RAM block: hold the output pipeline.
- `wr_valid`  out  1  host write request.
- `wr_ready`  in  1  host accepts the write this cycle.
- `wr_addr`  out  ADDR_W  host line address.
- `wr_data`  out  512  host write data.
- `busy`  out  1  high in every state except IDLE.
- `done`  out  1  one-cycle completion pulse.
- `line_count`  out  32  number of data lines written to the host in the current batch.
- `overflow_err`  out  1  sticky; set when a line is dropped because the FIFO was full.

## Operation
- FSM states: IDLE, ARM, STREAM, DRAIN, STATUS, DONE.
- IDLE
  - `start` latches `base_addr` and `status_addr` and clears `line_count`, the write index and the FIFO.
  - Then → ARM.
  - `start` in any other state is ignored.
- ARM
  - `output_permit`=0.
  - `output_request`=1 → STREAM.
- STREAM
  - `output_permit`=1.
  - `output_finish`=1 → DRAIN, and `output_permit` drops to 0 in that same transition.
- DRAIN
  - `output_permit`=0.
  - FIFO empty and no data write outstanding → STATUS.
- STATUS
  - `wr_valid`=1, `wr_addr`=`status_addr`.
  - `wr_data`: [31:0]=32'h534D454D, [63:32]=`line_count`, [64]=`overflow_err`, all other bits 0.
  - `wr_ready` → DONE.
- DONE
  - `done`=1 for exactly one cycle, then → IDLE.
- Capture
  - Push `output_data` when `output_valid`=1 and the state is STREAM or DRAIN.
  - `output_valid` in any other state is ignored.
  - `output_valid` is honoured regardless of `stall`.
- Issue
  - In STREAM and DRAIN: `wr_valid` = FIFO not empty, `wr_data` = FIFO head, `wr_addr` = `base_addr` + write index (modulo 2^ADDR_W).
  - On `wr_valid`&&`wr_ready`: pop the FIFO, increment the write index, increment `line_count` (wraps at 2^32).
- Boundaries
  - Push and pop in the same cycle: both take effect and occupancy is unchanged, even when the FIFO is full.
  - Push when full with no pop: the line is dropped and `overflow_err` is set to 1 until `reset` or the next `start`.
  - Empty FIFO: `wr_valid`=0 and `wr_addr`/`wr_data` are don't-care.
  - Once `wr_valid` is asserted, `wr_data`/`wr_addr` must hold until `wr_ready`.
- Stall
  - Registered: `stall` <= (next occupancy >= STALL_THRESH).
  - Forced to 0 outside STREAM/DRAIN.
  - The 4-entry margin absorbs the RAM block's one-cycle valid latency plus the registered stall.

## Timing
- Every output resets to 0, as do occupancy, write index and state (IDLE).
- `reset` mid-batch: at the next edge every output is 0 and any buffered lines are discarded.
- `start` → ARM on the next edge; `output_permit` rises on the edge that samples `output_request`=1.
- Capture to host: a line pushed at edge t gives `wr_valid`=1 with that data in cycle t+1, provided the FIFO was empty.
- Full throughput is one line per cycle when `wr_ready` is held at 1.
- `stall` changes one cycle after the occupancy change that causes it.
- `output_finish` sampled at edge t → `output_permit`=0 after edge t.
- DRAIN → STATUS on the edge after the last data pop.
- `done` is high in the cycle after the status write handshake.

## Test plan
- Basic batch:
  - Stimulus: `start` with `base_addr`=0x100, `status_addr`=0x40; `output_request`; 5 valid lines D0–D4 back-to-back; `output_finish`; `wr_ready`=1.
  - Required: writes of D0–D4 to 0x100–0x104 in order, then a status write to 0x40 with [63:32]=5 and [31:0]=0x534D454D, then one `done` pulse.
- Back-pressure:
  - Stimulus: `wr_ready`=0 while 12 lines arrive.
  - Required: `stall`=1 from the cycle after occupancy reaches 12; no loss; `overflow_err`=0 after `wr_ready` is released; `line_count`=12.
- Overflow:
  - Stimulus: `wr_ready`=0 and 17 lines pushed into a 16-deep FIFO.
  - Required: the 17th line is dropped; `overflow_err`=1; exactly 16 data writes; status bit 64 = 1.
- Simultaneous push/pop:
  - Stimulus: FIFO full, `output_valid`=1 and `wr_ready`=1 in the same cycle.
  - Required: occupancy stays 16; `overflow_err`=0.
- Reset mid-STREAM:
  - Stimulus: assert `reset` after 3 lines.
  - Required: `output_permit`, `wr_valid`, `stall`, `busy` are all 0 at the next edge; a following `start` batch behaves like the basic batch.
- Address wrap and ignored start:
  - Stimulus: `base_addr`=2^32-2 with 4 lines; a second `start` pulse during STREAM.
  - Required: writes go to FFFFFFFE, FFFFFFFF, 0, 1; the second `start` has no effect.

Source files
------------

// File: rtl/smem_result_writer.sv
// -----------------------------------------------------------------------------
// smem_result_writer
//
// Drain stage for the SMEM result RAM block. After the RAM block raises
// output_request, this block grants output_permit and captures the 512-bit
// result lines. The lines wait in a small FIFO, and stall back-pressures the
// RAM block. The lines are then issued as sequential host line-writes. A batch
// ends with one status line and a single-cycle done pulse.
//
// Ports
//   clk, reset              clock, synchronous active-high reset
//   start                   one-cycle pulse, arms a batch (honoured in IDLE only)
//   base_addr, status_addr  host line addresses, latched on start
//   output_request/permit   request/grant handshake with the RAM block
//   output_data/valid       result line stream from the RAM block
//   output_finish           RAM block has sent every line (sticky)
//   stall                   registered back-pressure to the RAM block
//   wr_valid/ready/addr/data host line-write channel
//   busy, done              status; done is a one-cycle pulse
//   line_count              data lines written in the current batch
//   overflow_err            sticky: a line was dropped on a full FIFO
//   dbg_state_o             current FSM state encoding
//   dbg_occupancy_o         current FIFO occupancy
//
// Host write handshake: a beat transfers on a rising edge where both wr_valid
// and wr_ready are high. Once wr_valid rises, wr_addr and wr_data hold steady
// until that transfer. wr_valid does not depend on wr_ready.
// -----------------------------------------------------------------------------
module smem_result_writer #(
    parameter int FIFO_DEPTH   = 16,
    parameter int STALL_THRESH = FIFO_DEPTH - 4,
    parameter int ADDR_W       = 32
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          start,
    input  logic [ADDR_W-1:0]             base_addr,
    input  logic [ADDR_W-1:0]             status_addr,
    input  logic                          output_request,
    output logic                          output_permit,
    input  logic [511:0]                  output_data,
    input  logic                          output_valid,
    input  logic                          output_finish,
    output logic                          stall,
    output logic                          wr_valid,
    input  logic                          wr_ready,
    output logic [ADDR_W-1:0]             wr_addr,
    output logic [511:0]                  wr_data,
    output logic                          busy,
    output logic                          done,
    output logic [31:0]                   line_count,
    output logic                          overflow_err,
    output logic [2:0]                    dbg_state_o,
    output logic [$clog2(FIFO_DEPTH):0]   dbg_occupancy_o
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] DEPTH_C  = CW'(FIFO_DEPTH);
    localparam logic [CW-1:0] THRESH_C = CW'(STALL_THRESH);
    localparam logic [31:0]   MAGIC_C  = 32'h534D454D;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_ARM    = 3'd1,
        S_STREAM = 3'd2,
        S_DRAIN  = 3'd3,
        S_STATUS = 3'd4,
        S_DONE   = 3'd5
    } state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   base_q, base_d;
    logic [ADDR_W-1:0]   status_q, status_d;
    logic [ADDR_W-1:0]   wr_idx_q, wr_idx_d;
    logic [31:0]         line_count_q, line_count_d;
    logic                ovf_q, ovf_d;
    logic                stall_q, stall_d;
    logic [PW-1:0]       rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]       wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]       count_q, count_d;
    logic [511:0]        mem_q [FIFO_DEPTH];

    logic active, fifo_empty, fifo_full;
    logic data_pop, push_req, push, drop;

    always_comb begin
        active     = (state_q == S_STREAM) || (state_q == S_DRAIN);
        fifo_empty = (count_q == '0);
        fifo_full  = (count_q == DEPTH_C);
        data_pop   = active && !fifo_empty && wr_ready;
        push_req   = active && output_valid;
        // A full FIFO still accepts a line when the head leaves on the same edge.
        push       = push_req && (!fifo_full || data_pop);
        drop       = push_req && fifo_full && !data_pop;

        state_d      = state_q;
        base_d       = base_q;
        status_d     = status_q;
        wr_idx_d     = wr_idx_q;
        line_count_d = line_count_q;
        ovf_d        = ovf_q;
        rd_ptr_d     = rd_ptr_q;
        wr_ptr_d     = wr_ptr_q;
        count_d      = count_q;

        if (push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (data_pop) begin
            rd_ptr_d     = rd_ptr_q + 1'b1;
            wr_idx_d     = wr_idx_q + 1'b1;
            line_count_d = line_count_q + 32'd1;
        end
        if (push && !data_pop) begin
            count_d = count_q + 1'b1;
        end else if (data_pop && !push) begin
            count_d = count_q - 1'b1;
        end
        if (drop) begin
            ovf_d = 1'b1;
        end

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    base_d       = base_addr;
                    status_d     = status_addr;
                    wr_idx_d     = '0;
                    line_count_d = '0;
                    ovf_d        = 1'b0;
                    rd_ptr_d     = '0;
                    wr_ptr_d     = '0;
                    count_d      = '0;
                    state_d      = S_ARM;
                end
            end
            S_ARM:    if (output_request) state_d = S_STREAM;
            S_STREAM: if (output_finish)  state_d = S_DRAIN;
            // A line arriving into an empty FIFO keeps us here so it is written.
            S_DRAIN:  if (fifo_empty && !push) state_d = S_STATUS;
            S_STATUS: if (wr_ready) state_d = S_DONE;
            S_DONE:   state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase

        stall_d = ((state_d == S_STREAM) || (state_d == S_DRAIN)) && (count_d >= THRESH_C);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_IDLE;
            base_q       <= '0;
            status_q     <= '0;
            wr_idx_q     <= '0;
            line_count_q <= '0;
            ovf_q        <= 1'b0;
            stall_q      <= 1'b0;
            rd_ptr_q     <= '0;
            wr_ptr_q     <= '0;
            count_q      <= '0;
        end else begin
            state_q      <= state_d;
            base_q       <= base_d;
            status_q     <= status_d;
            wr_idx_q     <= wr_idx_d;
            line_count_q <= line_count_d;
            ovf_q        <= ovf_d;
            stall_q      <= stall_d;
            rd_ptr_q     <= rd_ptr_d;
            wr_ptr_q     <= wr_ptr_d;
            count_q      <= count_d;
        end
    end

    // Line storage carries no reset; occupancy alone decides what is valid.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= output_data;
        end
    end

    // All outputs decode registered state, so they drop to 0 right after reset.
    always_comb begin
        output_permit   = (state_q == S_STREAM);
        wr_valid        = (active && !fifo_empty) || (state_q == S_STATUS);
        wr_addr         = '0;
        wr_data         = '0;
        if (state_q == S_STATUS) begin
            wr_addr = status_q;
            wr_data = {447'd0, ovf_q, line_count_q, MAGIC_C};
        end else if (wr_valid) begin
            wr_addr = base_q + wr_idx_q;
            wr_data = mem_q[rd_ptr_q];
        end
        busy            = (state_q != S_IDLE);
        done            = (state_q == S_DONE);
        stall           = stall_q;
        line_count      = line_count_q;
        overflow_err    = ovf_q;
        dbg_state_o     = state_q;
        dbg_occupancy_o = count_q;
    end

endmodule

// File: tb/tb_smem_result_writer.sv
module tb_smem_result_writer;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         start = 1'b0;
  logic [31:0]  base_addr = '0;
  logic [31:0]  status_addr = '0;
  logic         output_request = 1'b0;
  logic         output_permit;
  logic [511:0] output_data = '0;
  logic         output_valid = 1'b0;
  logic         output_finish = 1'b0;
  logic         stall;
  logic         wr_valid;
  logic         wr_ready = 1'b0;
  logic [31:0]  wr_addr;
  logic [511:0] wr_data;
  logic         busy;
  logic         done;
  logic [31:0]  line_count;
  logic         overflow_err;
  logic [2:0]   dbg_state;
  logic [4:0]   dbg_occupancy;

  int n_checks = 0;
  int n_fail = 0;

  // expected host writes: {addr, data}
  logic [543:0] exp_q[$];

  logic         hold_pending = 1'b0;
  logic [31:0]  hold_addr;
  logic [511:0] hold_data;

  smem_result_writer dut (
    .clk             (clk),
    .reset           (reset),
    .start           (start),
    .base_addr       (base_addr),
    .status_addr     (status_addr),
    .output_request  (output_request),
    .output_permit   (output_permit),
    .output_data     (output_data),
    .output_valid    (output_valid),
    .output_finish   (output_finish),
    .stall           (stall),
    .wr_valid        (wr_valid),
    .wr_ready        (wr_ready),
    .wr_addr         (wr_addr),
    .wr_data         (wr_data),
    .busy            (busy),
    .done            (done),
    .line_count      (line_count),
    .overflow_err    (overflow_err),
    .dbg_state_o     (dbg_state),
    .dbg_occupancy_o (dbg_occupancy)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL global_timeout: simulation did not finish, got still running expected finish");
    $fatal(1, "timeout");
  end

  // ---------------- helpers ----------------
  task automatic check(input string name, input logic [543:0] act, input logic [543:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [511:0] mk_line(input int tag, input int i);
    logic [31:0] w;
    w = (tag << 16) | i;
    return {16{w}};
  endfunction

  function automatic logic [511:0] st_line(input logic [31:0] lc, input logic ov);
    return {447'd0, ov, lc, 32'h534D454D};
  endfunction

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    if (reset) begin
      hold_pending = 1'b0;
    end else begin
      if (hold_pending) begin
        check("wr_hold_valid", {543'd0, wr_valid}, 544'd1);
        check("wr_hold_addr", {512'd0, wr_addr}, {512'd0, hold_addr});
        check("wr_hold_data", {32'd0, wr_data}, {32'd0, hold_data});
      end
      if (wr_valid && wr_ready) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_write: got addr %0h expected no write", wr_addr);
        end else begin
          logic [543:0] e;
          e = exp_q.pop_front();
          check("wr_addr", {512'd0, wr_addr}, {512'd0, e[543:512]});
          check("wr_data", {32'd0, wr_data}, {32'd0, e[511:0]});
        end
        hold_pending = 1'b0;
      end else if (wr_valid) begin
        hold_pending = 1'b1;
        hold_addr    = wr_addr;
        hold_data    = wr_data;
      end else begin
        hold_pending = 1'b0;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic reset_dut();
    reset = 1'b1;
    tick();
    tick();
    check("rst_permit", {543'd0, output_permit}, 544'd0);
    check("rst_wr_valid", {543'd0, wr_valid}, 544'd0);
    check("rst_stall", {543'd0, stall}, 544'd0);
    check("rst_busy", {543'd0, busy}, 544'd0);
    check("rst_done", {543'd0, done}, 544'd0);
    check("rst_line_count", {512'd0, line_count}, 544'd0);
    check("rst_overflow", {543'd0, overflow_err}, 544'd0);
    check("rst_wr_addr", {512'd0, wr_addr}, 544'd0);
    check("rst_wr_data", {32'd0, wr_data}, 544'd0);
    check("rst_occupancy", {539'd0, dbg_occupancy}, 544'd0);
    reset = 1'b0;
  endtask

  task automatic begin_batch(input logic [31:0] base, input logic [31:0] stat);
    start = 1'b1;
    base_addr = base;
    status_addr = stat;
    tick();
    start = 1'b0;
    check("arm_busy", {543'd0, busy}, 544'd1);
    check("arm_permit", {543'd0, output_permit}, 544'd0);
    check("arm_state", {541'd0, dbg_state}, 544'd1);
    output_request = 1'b1;
    tick();
    check("stream_permit", {543'd0, output_permit}, 544'd1);
    check("stream_state", {541'd0, dbg_state}, 544'd2);
  endtask

  task automatic send_line(input logic [511:0] d, input logic expect_write, input logic [31:0] addr);
    output_valid = 1'b1;
    output_data = d;
    if (expect_write) exp_q.push_back({addr, d});
    tick();
    output_valid = 1'b0;
  endtask

  task automatic wait_done();
    logic got;
    got = 1'b0;
    for (int i = 0; i < 300; i++) begin
      tick();
      if (done) begin
        got = 1'b1;
        break;
      end
    end
    check("done_seen", {543'd0, got}, 544'd1);
    if (got) begin
      tick();
      check("done_one_cycle", {543'd0, done}, 544'd0);
      check("idle_busy", {543'd0, busy}, 544'd0);
    end
  endtask

  task automatic finish_batch(input logic [31:0] stat, input logic [31:0] lc, input logic ov);
    output_finish = 1'b1;
    tick();
    check("finish_permit", {543'd0, output_permit}, 544'd0);
    exp_q.push_back({stat, st_line(lc, ov)});
    wait_done();
    output_finish = 1'b0;
    output_request = 1'b0;
    check("final_line_count", {512'd0, line_count}, {512'd0, lc});
    check("final_overflow", {543'd0, overflow_err}, {543'd0, ov});
    check("all_writes_seen", 544'(exp_q.size()), 544'd0);
  endtask

  task automatic run_basic(input int tag);
    wr_ready = 1'b1;
    begin_batch(32'h100, 32'h40);
    for (int i = 0; i < 5; i++) send_line(mk_line(tag, i), 1'b1, 32'h100 + i);
    finish_batch(32'h40, 32'd5, 1'b0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    tick();
    reset_dut();

    // basic batch
    run_basic(1);

    // a line offered while idle is ignored
    output_valid = 1'b1;
    output_data = mk_line(9, 9);
    tick();
    output_valid = 1'b0;
    check("idle_valid_occ", {539'd0, dbg_occupancy}, 544'd0);
    check("idle_valid_wr_valid", {543'd0, wr_valid}, 544'd0);

    // back-pressure: 12 lines with the host stalled
    wr_ready = 1'b0;
    begin_batch(32'h200, 32'h48);
    for (int i = 0; i < 12; i++) begin
      send_line(mk_line(2, i), 1'b1, 32'h200 + i);
      if (i == 10) check("bp_stall_at_11", {543'd0, stall}, 544'd0);
    end
    check("bp_stall_at_12", {543'd0, stall}, 544'd1);
    check("bp_occ_12", {539'd0, dbg_occupancy}, 544'd12);
    wr_ready = 1'b1;
    finish_batch(32'h48, 32'd12, 1'b0);

    // overflow: 17 lines into 16 entries
    wr_ready = 1'b0;
    begin_batch(32'h400, 32'h50);
    for (int i = 0; i < 17; i++) send_line(mk_line(3, i), (i < 16), 32'h400 + i);
    check("ovf_flag", {543'd0, overflow_err}, 544'd1);
    check("ovf_occ", {539'd0, dbg_occupancy}, 544'd16);
    wr_ready = 1'b1;
    finish_batch(32'h50, 32'd16, 1'b1);

    // simultaneous push and pop on a full FIFO
    wr_ready = 1'b0;
    begin_batch(32'h500, 32'h58);
    for (int i = 0; i < 16; i++) send_line(mk_line(4, i), 1'b1, 32'h500 + i);
    check("pp_full_occ", {539'd0, dbg_occupancy}, 544'd16);
    check("pp_full_stall", {543'd0, stall}, 544'd1);
    wr_ready = 1'b1;
    send_line(mk_line(4, 16), 1'b1, 32'h510);
    wr_ready = 1'b0;
    check("pp_occ_kept", {539'd0, dbg_occupancy}, 544'd16);
    check("pp_no_overflow", {543'd0, overflow_err}, 544'd0);
    wr_ready = 1'b1;
    finish_batch(32'h58, 32'd17, 1'b0);

    // reset in the middle of STREAM
    wr_ready = 1'b0;
    begin_batch(32'h300, 32'h60);
    for (int i = 0; i < 3; i++) send_line(mk_line(5, i), 1'b0, 32'h0);
    reset = 1'b1;
    tick();
    check("mid_rst_permit", {543'd0, output_permit}, 544'd0);
    check("mid_rst_wr_valid", {543'd0, wr_valid}, 544'd0);
    check("mid_rst_stall", {543'd0, stall}, 544'd0);
    check("mid_rst_busy", {543'd0, busy}, 544'd0);
    check("mid_rst_occ", {539'd0, dbg_occupancy}, 544'd0);
    reset = 1'b0;
    output_request = 1'b0;
    tick();
    run_basic(6);

    // address wrap with an ignored start during STREAM
    wr_ready = 1'b1;
    begin_batch(32'hFFFF_FFFE, 32'h70);
    send_line(mk_line(7, 0), 1'b1, 32'hFFFF_FFFE);
    send_line(mk_line(7, 1), 1'b1, 32'hFFFF_FFFF);
    start = 1'b1;
    base_addr = 32'h999;
    status_addr = 32'h777;
    tick();
    start = 1'b0;
    check("ign_start_state", {541'd0, dbg_state}, 544'd2);
    check("ign_start_permit", {543'd0, output_permit}, 544'd1);
    send_line(mk_line(7, 2), 1'b1, 32'h0);
    send_line(mk_line(7, 3), 1'b1, 32'h1);
    finish_batch(32'h70, 32'd4, 1'b0);

    tick();
    tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
